// File: rtl/clock_pkg.sv
// Shared encodings for the clock front panel: clk_mode values and button indices.
// Also used by clock_top to decode virtual buttons and the current mode.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_SET_DATE  = 2'd3
    } mode_e;

    localparam int NUM_BTN  = 4;
    localparam int NUM_RPT  = 3;   // buttons 0..2 auto-repeat; setampm does not
    localparam int BTN_1    = 0;
    localparam int BTN_2    = 1;
    localparam int BTN_3    = 2;
    localparam int BTN_AMPM = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One raw button: 2-flop synchronizer, debounce counter, stable level and
// a combinational rise strobe that is high for the cycle after stable goes 0->1.
module debounce_cell #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic mclk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    logic [1:0]       sync;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sync     <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync     <= {sync[0], raw};
            stable_d <= stable;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                // the level has now been held DB_CYCLES cycles
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/button_conditioner.sv
// Turns raw panel buttons into one-cycle virtual button pulses with auto-repeat,
// and steps clk_mode on each pMode press (pulses are blanked on a mode change).
module button_conditioner
    import clock_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic               mclk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] pButton,
    input  logic               pMode,
    output logic [NUM_BTN-1:0] vButton,
    output logic [1:0]         clk_mode
);

    localparam int NUM_IN = NUM_BTN + 1;
    localparam int CNT_W  = $clog2(max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [NUM_IN-1:0] raw, stable, rise;
    logic              mode_rise;

    assign raw       = {pMode, pButton};
    assign mode_rise = rise[NUM_BTN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_cell
        debounce_cell #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_cell (
            .mclk   (mclk),
            .rst    (rst),
            .raw    (raw[g]),
            .stable (stable[g]),
            .rise   (rise[g])
        );
    end

    logic [NUM_RPT-1:0][CNT_W-1:0] rep_cnt;
    logic [NUM_RPT-1:0]            rep_first, rep_fire;
    logic [NUM_BTN-1:0]            pulse;

    // rep_cnt counts edges since the last press/repeat pulse of that button
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < NUM_RPT; i++) begin
            rep_fire[i] = stable[i] & ~rise[i] &
                          (rep_first[i] ? (rep_cnt[i] == CNT_W'(REPEAT_DELAY - 1))
                                        : (rep_cnt[i] == CNT_W'(REPEAT_PERIOD - 1)));
        end
    end

    assign pulse = rise[NUM_BTN-1:0] | {{(NUM_BTN-NUM_RPT){1'b0}}, rep_fire};

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            rep_cnt   <= '0;
            rep_first <= '0;
            vButton   <= '0;
            clk_mode  <= MODE_RUN;
        end else begin
            for (int i = 0; i < NUM_RPT; i++) begin
                if (!stable[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                end else if (rise[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
                end
            end
            // a suppressed pulse is dropped; the repeat timers above keep running
            vButton <= mode_rise ? '0 : pulse;
            if (mode_rise)
                clk_mode <= clk_mode + 2'd1;
        end
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4: consecutive mclk cycles an input must hold a new level before it is accepted (20_000_000/50 on the board).
REQ-002 SHALL have parameter REPEAT_DELAY, default 20: mclk cycles from a press pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 8: mclk cycles between later auto-repeat pulses.
REQ-004 SHALL have port mclk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pButton, input, 4, raw asynchronous physical buttons: 0/1/2 = button1/2/3, 3 = setampm.
REQ-007 SHALL have port pMode, input, 1, raw asynchronous mode-select button.
REQ-008 SHALL have port vButton, output, 4, virtual button pulses for clock_top.
REQ-009 SHALL have port clk_mode, output, 2, mode for clock_top: 0 run, 1 set time, 2 set alarm, 3 set date.

Function
REQ-010 SHALL pass each of the 5 raw inputs through a 2-flop synchronizer before any other use.
REQ-011 SHALL hold one debounced "stable" level per input, and one cycle counter per input.
REQ-012 SHALL clear an input's counter on any cycle where its synchronized value equals its stable level.
REQ-013 SHALL increment an input's counter while the synchronized value differs from the stable level; on the cycle it would reach DB_CYCLES, SHALL flip the stable level and clear the counter.
REQ-014 SHALL make a press pulse on vButton[i] last exactly one mclk cycle, registered on the edge after stable[i] goes 0->1.
REQ-015 SHALL produce no vButton pulse when a button is released.
REQ-016 SHALL take exactly DB_CYCLES+3 mclk edges from the first edge that samples a clean rising level to vButton high.
REQ-017 SHALL auto-repeat vButton[0..2] while stable is high: one pulse REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles.
REQ-018 SHALL clear the repeat counter when stable goes low, so that no repeat pulse is issued on or after that cycle.
REQ-019 SHALL never auto-repeat vButton[3] (setampm); it pulses once per press.
REQ-020 SHALL increment clk_mode modulo 4 (3->0) on the edge where a pMode press pulse would be registered; pMode never auto-repeats.
REQ-021 SHALL suppress all vButton pulses, press or repeat, on the cycle clk_mode changes; a suppressed press SHALL NOT be re-issued, but its repeat schedule still runs.
REQ-022 SHALL handle each button independently, so that simultaneous presses on different buttons produce pulses in the same cycle.
REQ-023 SHALL size each counter to ceil(log2(max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1)) bits, and no counter SHALL wrap.

Reset
REQ-024 SHALL, while rst is low, immediately force vButton=0, clk_mode=0, and all synchronizer, stable, debounce-counter and repeat-counter state to 0.
REQ-025 SHALL treat a button held through reset deassertion as a new press: one pulse DB_CYCLES+3 edges after rst rises.

Structure
REQ-026 SHALL place the clk_mode encodings (MODE_RUN=0, MODE_SET_TIME=1, MODE_SET_ALARM=2, MODE_SET_DATE=3) and button index constants in shared package clock_pkg, which clock_top also uses.
REQ-027 SHALL put synchronizer, debounce counter, stable level and rising-edge pulse in sub-module debounce_cell, instantiated 5 times.
REQ-028 SHALL implement repeat timers and the mode counter in button_conditioner.

Verification (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; cycle numbers count edges from first sampling edge = 1)
REQ-029 SHALL verify a clean press: pButton[0] high for 10 cycles -> vButton[0] high for cycle 7 only; no pulse on release.
REQ-030 SHALL verify bounce rejection: pButton[1] toggles every 2 cycles for 12 cycles, then stays high -> exactly one pulse, 7 edges after its last rising transition.
REQ-031 SHALL verify auto-repeat: pButton[2] held 44 cycles -> pulses at cycles 7, 27, 35 and 43 only; none after the release is debounced.
REQ-032 SHALL verify no repeat on setampm: pButton[3] held 60 cycles -> exactly one vButton[3] pulse, at cycle 7.
REQ-033 SHALL verify mode cycling and collision: four separate pMode presses -> clk_mode goes 1,2,3,0; then pMode and pButton[0] rise together -> clk_mode goes to 1 and vButton stays 0 that cycle.
REQ-034 SHALL verify reset mid-hold: rst pulled low during a pButton[1] hold with clk_mode=2 -> vButton=0 and clk_mode=0 at once; after rst rises with the button still held, one pulse at edge 7.
